can_rx_fifo: RTL and testbench
==============================

// Module: can_rx_fifo
// PURPOSE
//  Receive-side message buffer. Sits between the CAN bit-level receiver and the host.
//  Applies an 11-bit code/mask acceptance filter to each completed frame.
//  Stores accepted frames in a circular FIFO. The host reads them in arrival order.
//  Reports full, empty, fill level and a sticky overrun flag.
// PARAMETERS
//  DEPTH  4  number of frame slots; must be a power of 2 and at least 2
// PORTS
//  clk          in   1        system clock; all state updates on rising edge
//  rst          in   1        asynchronous, active-high reset
//  rx_valid     in   1        1-cycle strobe: a completed, CRC-clean frame is on rx_*
//  rx_id        in   11       received standard identifier
//  rx_dlc       in   4        received data length code
//  rx_data      in   8x[0:7]  received payload bytes
//  acc_code     in   11       acceptance code
//  acc_mask     in   11       acceptance mask; 1 = don't-care bit
//  re           in   1        host read/pop strobe
//  rd_id        out  11       identifier of the head frame
//  rd_dlc       out  4        DLC of the head frame
//  rd_data      out  8x[0:7]  payload of the head frame
//  empty        out  1        FIFO holds no frame
//  full         out  1        FIFO holds DEPTH frames
//  count        out  $clog2(DEPTH)+1  number of stored frames
//  overrun      out  1        sticky: an accepted frame was lost because the FIFO was full
//  clr_overrun  in   1        clears overrun
// BEHAVIOUR
//  Reset: pointers=0, count=0, empty=1, full=0, overrun=0, rd_*=0. Storage contents are don't-care.
//  Acceptance: accept = rx_valid && (((rx_id ^ acc_code) & ~acc_mask) == 0).
//    Rejected frames leave all state unchanged.
//  Write: an accepted frame is stored at wr_ptr on the same edge, and wr_ptr increments.
//    DLC > 8 is stored as 8.
//  Read: first-word fall-through. rd_* show the head slot combinationally while !empty,
//    and are forced to 0 while empty. re pops on the edge and rd_ptr increments.
//    re while empty is ignored and is not an error.
//  Latency: a frame accepted at edge N is visible on rd_* and clears empty after edge N.
//  Pointers: $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty.
//    Pointers wrap naturally modulo 2*DEPTH.
//  count = wr_ptr - rd_ptr (modulo). full = (count == DEPTH). empty = (count == 0).
//    All three are registered or derived from registered pointers only.
//  Simultaneous accepted write and re:
//    - not empty: both happen, count is unchanged. This includes the full case:
//      the head is popped and the new frame takes the freed slot, and overrun is not set.
//    - empty: the write happens, the re is ignored, and count becomes 1.
//  Full, with an accepted write and no re: the frame is dropped, overrun is set to 1,
//    and no storage or pointer changes.
//  Overrun is set and cleared only as stated: set on a drop, cleared by clr_overrun.
//    If set and clear occur on the same edge, set wins.
//  A reset mid-operation discards all stored frames immediately (asynchronous).
//    The filter has no internal state.
// STRUCTURE
//  Shared package can_pkg holds:
//    - typedef can_frame_t {logic [10:0] id; logic [3:0] dlc; logic [7:0] data[0:7];}
//    - localparam CAN_MAX_DLC = 8
//    - function clamp_dlc()
//  Sub-module can_acceptance_filter: purely combinational (rx_id, acc_code, acc_mask -> hit).
//    It will be reused by the future multi-filter bank.
//  Storage is an array of can_frame_t indexed by the pointer LSBs.
// TESTING
//  Use DEPTH=4 unless stated otherwise. Write rx_data[i] = i + rx_id[7:0].
//  Run the self-checking scenarios below and print a pass/fail summary with the error count.
//  1 Ordering: acc_mask=7FF; write 300, 500, 400, then re x3
//    -> rd_id reads 300, 500, 400; payload matches; empty=1 afterwards.
//  2 Filter: acc_code=120, acc_mask=00F; write 123, 130, 12F
//    -> count=2; reads return 123 then 12F; 130 is never stored.
//  3 Full/overrun: write 10, 20, 30, 40 -> full=1, count=4.
//    Then write 50 -> overrun=1, count=4, and the head is still 10.
//    Then pulse clr_overrun -> overrun=0.
//  4 Full with simultaneous re and write of 60 -> overrun stays 0, count=4.
//    Subsequent reads return 20, 30, 40, 60, which exercises pointer wrap.
//  5 Edge cases:
//    - re while empty -> no change; count=0; rd_* = 0.
//    - write with rx_dlc=F -> rd_dlc=8.
//    - assert rst with 2 frames stored -> empty=1 and count=0 immediately, before any clock edge.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN frame type and helpers for the receive path.
// No logic of its own; consumed by the FIFO and its testbench.
// No flow control here.
package can_pkg;

  localparam int CAN_MAX_DLC = 8;

  // Payload byte 0 sits in the most significant byte of data.
  typedef struct packed {
    logic [10:0]     id;
    logic [3:0]      dlc;
    logic [0:7][7:0] data;
  } can_frame_t;

  // DLC codes 9..15 still carry only 8 bytes on classic CAN.
  function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
    return (dlc > 4'(CAN_MAX_DLC)) ? 4'(CAN_MAX_DLC) : dlc;
  endfunction

endpackage

// File: rtl/can_rx_fifo_if.sv
// Receiver-to-host bundle: frame strobe, filter setup, head-of-queue view and status.
// Pure wiring, no latency.
// The receiver cannot be stalled; frames arriving while full are dropped and flagged.
interface can_rx_fifo_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic            rx_valid;
  logic [10:0]     rx_id;
  logic [3:0]      rx_dlc;
  logic [0:7][7:0] rx_data;
  logic [10:0]     acc_code;
  logic [10:0]     acc_mask;
  logic            re;
  logic            clr_overrun;
  logic [10:0]     rd_id;
  logic [3:0]      rd_dlc;
  logic [0:7][7:0] rd_data;
  logic            empty;
  logic            full;
  logic [CW-1:0]   count;
  logic            overrun;

  // Receiver/host side.
  modport master (
    output rx_valid, rx_id, rx_dlc, rx_data, acc_code, acc_mask, re, clr_overrun,
    input  rd_id, rd_dlc, rd_data, empty, full, count, overrun
  );

  // Buffer side.
  modport slave (
    input  rx_valid, rx_id, rx_dlc, rx_data, acc_code, acc_mask, re, clr_overrun,
    output rd_id, rd_dlc, rd_data, empty, full, count, overrun
  );
endinterface

// File: rtl/can_acceptance_filter.sv
// Single code/mask acceptance filter for an 11-bit standard identifier.
// Combinational, zero latency.
// No flow control; hit is a pure function of its inputs.
module can_acceptance_filter (
  input  logic [10:0] rx_id,
  input  logic [10:0] acc_code,
  input  logic [10:0] acc_mask,
  output logic        hit
);
  // A mask bit of 1 makes that identifier bit a don't-care.
  assign hit = (((rx_id ^ acc_code) & ~acc_mask) == 11'd0);
endmodule

// File: rtl/can_rx_fifo.sv
// Filtered receive FIFO of CAN frames with first-word fall-through head view.
// Accepted frame is visible on rd_* the cycle after its write edge.
// No backpressure to the receiver: writes to a full FIFO are dropped and set sticky overrun.
module can_rx_fifo
  import can_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  can_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] cnt;
  logic          overrun_q;
  can_frame_t    mem [DEPTH];
  can_frame_t    wr_frame;
  can_frame_t    head;
  logic          hit;
  logic          accept;
  logic          is_empty;
  logic          is_full;
  logic          do_pop;
  logic          do_wr;
  logic          drop;

  can_acceptance_filter u_filter (
    .rx_id    (bus.rx_id),
    .acc_code (bus.acc_code),
    .acc_mask (bus.acc_mask),
    .hit      (hit)
  );

  // Status comes only from the registered pointers; the extra MSB separates full from empty.
  assign cnt      = wr_ptr - rd_ptr;
  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == PW'(DEPTH));

  // A pop frees a slot on the same edge, so a full FIFO can still take a write alongside re.
  assign accept = bus.rx_valid && hit;
  assign do_pop = bus.re && !is_empty;
  assign do_wr  = accept && (!is_full || do_pop);
  assign drop   = accept && is_full && !do_pop;

  // Assemble the frame to store, clamping oversize DLC codes.
  always_comb begin
    wr_frame      = '0;
    wr_frame.id   = bus.rx_id;
    wr_frame.dlc  = clamp_dlc(bus.rx_dlc);
    wr_frame.data = bus.rx_data;
  end

  // Pointer and sticky-overrun state; a drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop)
        overrun_q <= 1'b1;
      else if (bus.clr_overrun)
        overrun_q <= 1'b0;
    end
  end

  // Frame storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_frame;
  end

  assign head = mem[rd_ptr[AW-1:0]];

  // Head view is zeroed while empty so stale slots never leak to the host.
  assign bus.rd_id   = is_empty ? '0 : head.id;
  assign bus.rd_dlc  = is_empty ? '0 : head.dlc;
  assign bus.rd_data = is_empty ? '0 : head.data;
  assign bus.empty   = is_empty;
  assign bus.full    = is_full;
  assign bus.count   = cnt;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_can_rx_fifo.sv
module tb_can_rx_fifo;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  can_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  can_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } mfr_t;

  typedef struct {
    int   cnt;
    bit   ovr;
    mfr_t head;
  } exp_t;

  mfr_t        mq[$];
  exp_t        sb[$];
  bit          m_ovr;
  logic [10:0] tb_code;
  logic [10:0] tb_mask;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [63:0] payload(input logic [10:0] id);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p[63-8*i -: 8] = 8'(i) + id[7:0];
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock of stimulus; records what the outputs must show now, then advances the model.
  task automatic cyc(input logic v, input logic [10:0] id, input logic [3:0] dlc,
                     input logic r, input logic clr);
    exp_t e;
    mfr_t f;
    bit   acc;
    @(negedge clk);
    bus.rx_valid    = v;
    bus.rx_id       = id;
    bus.rx_dlc      = dlc;
    bus.rx_data     = payload(id);
    bus.re          = r;
    bus.clr_overrun = clr;
    bus.acc_code    = tb_code;
    bus.acc_mask    = tb_mask;

    e.cnt  = mq.size();
    e.ovr  = m_ovr;
    e.head = '{id: '0, dlc: '0, data: '0};
    if (mq.size() > 0) e.head = mq[0];
    sb.push_back(e);

    acc = v && (((id ^ tb_code) & ~tb_mask) == 11'd0);
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (acc && mq.size() < DEPTH) begin
      f.id   = id;
      f.dlc  = (dlc > 4'd8) ? 4'd8 : dlc;
      f.data = payload(id);
      mq.push_back(f);
    end else if (acc) begin
      m_ovr = 1'b1;
    end else if (clr) begin
      m_ovr = 1'b0;
    end
    if (clr && !(acc && mq.size() == DEPTH && !(r && e.cnt > 0) && e.cnt == DEPTH))
      m_ovr = (acc && e.cnt == DEPTH && !(r && e.cnt > 0)) ? 1'b1 : 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 11'h000, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [10:0] id);
    cyc(1'b1, id, 4'd8, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 11'h000, 4'd0, 1'b1, 1'b0);
  endtask

  // Monitor: compares the DUT's presented outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("count",   64'(bus.count),   64'(e.cnt));
        check("empty",   64'(bus.empty),   64'(e.cnt == 0));
        check("full",    64'(bus.full),    64'(e.cnt == DEPTH));
        check("overrun", 64'(bus.overrun), 64'(e.ovr));
        check("rd_id",   64'(bus.rd_id),   64'(e.head.id));
        check("rd_dlc",  64'(bus.rd_dlc),  64'(e.head.dlc));
        check("rd_data", bus.rd_data,      e.head.data);
      end
    end
  end

  initial begin
    rst             = 1'b1;
    bus.rx_valid    = 1'b0;
    bus.rx_id       = '0;
    bus.rx_dlc      = '0;
    bus.rx_data     = '0;
    bus.re          = 1'b0;
    bus.clr_overrun = 1'b0;
    bus.acc_code    = '0;
    bus.acc_mask    = 11'h7FF;
    tb_code         = '0;
    tb_mask         = 11'h7FF;
    m_ovr           = 1'b0;
    #3;
    check("rst_empty",   64'(bus.empty),   64'd1);
    check("rst_count",   64'(bus.count),   64'd0);
    check("rst_full",    64'(bus.full),    64'd0);
    check("rst_overrun", 64'(bus.overrun), 64'd0);
    check("rst_rd_id",   64'(bus.rd_id),   64'd0);
    #9;
    rst = 1'b0;

    // Ordering through an open filter.
    wr(11'h300); wr(11'h500); wr(11'h400);
    rd(); rd(); rd(); idle();
    #1 check("s1_empty", 64'(bus.empty), 64'd1);

    // Code/mask filter: 0x130 differs in a cared-about bit.
    tb_code = 11'h120; tb_mask = 11'h00F;
    wr(11'h123); wr(11'h130); wr(11'h12F); idle();
    #1 check("s2_count", 64'(bus.count), 64'd2);
    rd(); rd(); idle();

    // Fill, overflow, then clear the sticky flag.
    tb_code = '0; tb_mask = 11'h7FF;
    wr(11'h010); wr(11'h020); wr(11'h030); wr(11'h040); idle();
    #1 check("s3_full", 64'(bus.full), 64'd1);
    check("s3_count", 64'(bus.count), 64'd4);
    wr(11'h050); idle();
    #1 check("s3_overrun", 64'(bus.overrun), 64'd1);
    check("s3_count_after_drop", 64'(bus.count), 64'd4);
    check("s3_head", 64'(bus.rd_id), 64'h010);
    cyc(1'b0, 11'h000, 4'd0, 1'b0, 1'b1); idle();
    #1 check("s3_clr", 64'(bus.overrun), 64'd0);

    // Full with simultaneous pop and write; drain across the wrap.
    cyc(1'b1, 11'h060, 4'd8, 1'b1, 1'b0); idle();
    #1 check("s4_overrun", 64'(bus.overrun), 64'd0);
    check("s4_count", 64'(bus.count), 64'd4);
    rd(); rd(); rd(); rd(); idle();

    // Edge cases: pop while empty, oversize DLC, async reset with data held.
    rd(); idle();
    #1 check("s5_count", 64'(bus.count), 64'd0);
    check("s5_rd_data", bus.rd_data, 64'd0);
    cyc(1'b1, 11'h077, 4'hF, 1'b0, 1'b0); idle();
    #1 check("s5_dlc", 64'(bus.rd_dlc), 64'd8);
    rd(); wr(11'h111); wr(11'h222); idle();
    #3 rst = 1'b1;
    #1 check("s5_rst_empty", 64'(bus.empty), 64'd1);
    check("s5_rst_count", 64'(bus.count), 64'd0);
    rst = 1'b0;
    mq.delete();
    m_ovr = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        tb_code = 11'($urandom);
        tb_mask = ($urandom_range(0, 2) == 0) ? 11'h7FF : 11'($urandom);
      end
      cyc(1'($urandom_range(0, 1)), 11'($urandom), 4'($urandom),
          ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0));
    end
    idle(); idle();
    @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
